fir_mac_sequencer: RTL
======================

// Module: fir_mac_sequencer
// PURPOSE
//  Time-multiplexed FIR controller: one signed 8x8 multiplier is shared across all TAPS of a direct-form FIR.
//  Per accepted sample: shift the delay line, run TAPS multiply-accumulate cycles, present one result.
//  Sits between the sample source and the output consumer of the DSP chain; coefficients are loaded by the host.
// PARAMETERS
//  TAPS   8                   number of filter taps (>=2, power of 2)
//  ACC_W  16+$clog2(TAPS)     accumulator/output width; cannot overflow for any 8-bit inputs
// PORTS
//  clk        in   1      sole clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      sample offered
//  in_ready   out  1      sequencer accepts a sample (state IDLE)
//  in_data    in   8      signed sample
//  coef_we    in   1      coefficient write strobe
//  coef_addr  in   clog2(TAPS)  tap index
//  coef_data  in   8      signed coefficient
//  coef_err   out  1      sticky: a write arrived outside IDLE and was dropped
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_data   out  ACC_W  signed result sum(c[k]*x[k])
// BEHAVIOUR
//  Reset (async, any state incl. mid-MAC): state=IDLE, delay line x[*]=0, coefficients c[*]=0, acc=0,
//    out_valid=0, out_data=0, coef_err=0, in_ready=1 once rst deasserts; in-flight sample discarded.
//  FSM IDLE -> MAC -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready: x[0]<=in_data, x[k]<=x[k-1], acc<=0, idx<=0, go MAC.
//   MAC: in_ready=0. Each cycle acc<=acc+sext(x[idx]*c[idx]), idx++. Exactly TAPS cycles, then DONE.
//   DONE: out_valid=1, out_data held stable until out_valid&out_ready; then IDLE.
//  Latency: handshake in cycle 0 -> MAC cycles 1..TAPS -> out_valid high from cycle TAPS+1.
//  Throughput: one sample per TAPS+2 cycles with out_ready tied high.
//  Arithmetic: product is signed 16-bit (full range incl. -128*-128=+16384), sign-extended to ACC_W.
//  Coefficients: written in IDLE only (takes effect next sample). coef_we outside IDLE: write dropped,
//    coef_err<=1 (cleared by reset only). Simultaneous coef_we and sample handshake in IDLE:
//    the write lands and the new sample's computation uses it.
//  in_valid while not IDLE: ignored, no state change; source must hold the sample.
//  out_data changes only on the DONE entry edge; it holds the last result after handshake.
// CONFIGURATION
//  FIR_SAT_EN defined: out_data clamped to 16-bit signed range [-32768,+32767], sign-extended to ACC_W.
//  FIR_SAT_EN undefined: out_data = full-precision acc, no clamp.
// STRUCTURE
//  Shared package dsp_pkg: FSM state encodings (IDLE/MAC/DONE), PROD_W=16, SAMPLE_W=8,
//    SAT_MAX=16'sh7FFF, SAT_MIN=-16'sh8000, ACC_W derivation function.
//  One sub-module: the existing 8x8 signed multiplier (Multiplier8bit), instantiated once;
//    its operands are muxed from x[idx] and c[idx]. The coefficient RAM and delay line stay inline.
// TESTING (TAPS=4)
//  Impulse/step: c={1,2,3,4}; samples 10 then 20 -> out_data 10, then 40 (20*1+10*2); valid at cycle 5.
//  Extremes: c[*]=-128, four samples -128 -> 4th result 65536; FIR_SAT_EN -> 32767.
//  Back-pressure: out_ready low 5 cycles in DONE -> out_data and out_valid held, in_ready=0 throughout.
//  Illegal write: coef_we in MAC (addr 0, data 5) -> c[0] unchanged, coef_err=1 and stays 1.
//  Reset mid-MAC (cycle 2): out_valid=0, out_data=0, state IDLE; next sample 7 with c={1,..} -> 7.
//  Back-to-back: in_valid held high, out_ready=1 -> one in_ready pulse every 6 cycles, results in order.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP definitions: sequencer state encoding, datapath widths, saturation limits
// and the accumulator width rule.
package dsp_pkg;

  localparam int SAMPLE_W = 8;
  localparam int PROD_W   = 16;

  localparam logic signed [PROD_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [PROD_W-1:0] SAT_MIN = -16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } fir_state_e;

  // Enough headroom that summing taps full-scale products can never overflow.
  function automatic int acc_w(input int taps);
    return PROD_W + $clog2(taps);
  endfunction

endpackage

// File: rtl/Multiplier8bit.sv
// Signed 8x8 -> 16 multiplier; full range including -128 * -128 = +16384.
module Multiplier8bit
  import dsp_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [SAMPLE_W-1:0] b,
  output logic signed [PROD_W-1:0]   p
);

  assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed direct-form FIR: one shared multiplier walks all taps per sample.
// Optional FIR_SAT_EN clamps the result to the 16-bit signed range.
module fir_mac_sequencer
  import dsp_pkg::*;
#(
  parameter int TAPS  = 8,
  parameter int ACC_W = acc_w(TAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] in_data,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [SAMPLE_W-1:0] coef_data,
  output logic                       coef_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    out_data
);

  localparam int IDX_W = $clog2(TAPS);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a source holds valid and data stable until that edge, ready never depends on valid.

  fir_state_e                 state_q, state_d;
  logic signed [SAMPLE_W-1:0] x_q [TAPS];
  logic signed [SAMPLE_W-1:0] x_d [TAPS];
  logic signed [SAMPLE_W-1:0] c_q [TAPS];
  logic signed [SAMPLE_W-1:0] c_d [TAPS];
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W-1:0]    out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic                       in_ready_q, in_ready_d;
  logic                       coef_err_q, coef_err_d;

  logic signed [SAMPLE_W-1:0] mul_a, mul_b;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [ACC_W-1:0]    result;

  assign mul_a = x_q[idx_q];
  assign mul_b = c_q[idx_q];

  Multiplier8bit u_mult (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  assign prod_ext = ACC_W'(prod);
  assign acc_sum  = acc_q + prod_ext;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN);

  always_comb begin
    result = acc_sum;
    if (acc_sum > SAT_HI) begin
      result = SAT_HI;
    end else if (acc_sum < SAT_LO) begin
      result = SAT_LO;
    end
  end
`else
  assign result = acc_sum;
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    coef_err_d  = coef_err_q;
    case (state_q)
      ST_IDLE: begin
        // A write landing with the sample handshake is seen by that sample's MAC pass.
        if (coef_we) begin
          c_d[coef_addr] = coef_data;
        end
        if (in_valid && in_ready_q) begin
          x_d[0] = in_data;
          for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_MAC;
        end
      end
      ST_MAC: begin
        if (coef_we) begin
          coef_err_d = 1'b1;
        end
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(TAPS - 1)) begin
          out_data_d  = result;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (coef_we) begin
          coef_err_d = 1'b1;
        end
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      coef_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      c_q         <= c_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      coef_err_q  <= coef_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign coef_err  = coef_err_q;

endmodule
